// File: rtl/init_pkg.sv
// rtl/init_pkg.sv - shared depths, widths, timeout and FSM states for the boot-time array loader
package init_pkg;

    localparam int BTB_DEPTH  = 256;
    localparam int BTB_AW     = 8;
    localparam int BTB_DW     = 40;
    localparam int BHT_DEPTH  = 256;
    localparam int BHT_AW     = 8;
    localparam int BHT_DW     = 2;
    localparam int REG_DEPTH  = 32;
    localparam int REG_AW     = 5;
    localparam int REG_DW     = 32;
    localparam int MEM_DEPTH  = 27;
    localparam int MEM_AW     = 5;
    localparam int MEM_DW     = 32;
    localparam int MEM_ADDR_W = 32;
    localparam int TIMEOUT    = 1024;
    localparam int TMR_W      = 11;

    typedef enum logic [1:0] {LOAD, DONE, ERR} init_state_t;

endpackage

// File: rtl/init_loader_if.sv
// rtl/init_loader_if.sv - init streams in, array write ports and boot status out
interface init_loader_if;
    import init_pkg::*;

    logic [BTB_DW-1:0]     btb_init;
    logic [BTB_AW-1:0]     btb_addr;
    logic [BHT_DW-1:0]     bht_init;
    logic [BHT_AW-1:0]     bht_addr;
    logic [REG_DW-1:0]     reg_init;
    logic [REG_AW-1:0]     reg_addr;
    logic [MEM_DW-1:0]     mem_init;
    logic [MEM_ADDR_W-1:0] mem_addr;

    logic                  btb_we_o;
    logic [BTB_AW-1:0]     btb_waddr_o;
    logic [BTB_DW-1:0]     btb_wdata_o;
    logic                  bht_we_o;
    logic [BHT_AW-1:0]     bht_waddr_o;
    logic [BHT_DW-1:0]     bht_wdata_o;
    logic                  rf_we_o;
    logic [REG_AW-1:0]     rf_waddr_o;
    logic [REG_DW-1:0]     rf_wdata_o;
    logic                  dmem_we_o;
    logic [MEM_ADDR_W-1:0] dmem_waddr_o;
    logic [MEM_DW-1:0]     dmem_wdata_o;
    logic                  cpu_rst_o;
    logic                  init_done_o;
    logic                  init_err_o;

    modport master (
        input  btb_init, btb_addr, bht_init, bht_addr,
        input  reg_init, reg_addr, mem_init, mem_addr,
        output btb_we_o, btb_waddr_o, btb_wdata_o,
        output bht_we_o, bht_waddr_o, bht_wdata_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o,
        output dmem_we_o, dmem_waddr_o, dmem_wdata_o,
        output cpu_rst_o, init_done_o, init_err_o
    );

    modport slave (
        output btb_init, btb_addr, bht_init, bht_addr,
        output reg_init, reg_addr, mem_init, mem_addr,
        input  btb_we_o, btb_waddr_o, btb_wdata_o,
        input  bht_we_o, bht_waddr_o, bht_wdata_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o,
        input  dmem_we_o, dmem_waddr_o, dmem_wdata_o,
        input  cpu_rst_o, init_done_o, init_err_o
    );

endinterface

// File: rtl/init_stream_tracker.sv
// rtl/init_stream_tracker.sv - picks each index once, in order, off a wrapping init stream
module init_stream_tracker #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 40,
    parameter int LAG   = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          addr_ok,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          done
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [AW-1:0] exp_idx;
    logic [AW-1:0] cmp_addr;
    logic          cmp_ok;
    logic          hit;

    // With LAG=1 the data on the wire belongs to last cycle's address.
    generate
        if (LAG != 0) begin : g_lag
            logic [AW-1:0] addr_d;
            logic          ok_d;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    addr_d <= '0;
                    ok_d   <= 1'b0;
                end else begin
                    addr_d <= addr;
                    ok_d   <= addr_ok;
                end
            end
            assign cmp_addr = addr_d;
            assign cmp_ok   = ok_d;
        end else begin : g_nolag
            assign cmp_addr = addr;
            assign cmp_ok   = addr_ok;
        end
    endgenerate

    assign hit = en & cmp_ok & ~done & (cmp_addr == exp_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we      <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
            done    <= 1'b0;
            exp_idx <= '0;
        end else begin
            we <= hit;
            if (hit) begin
                waddr <= cmp_addr;
                wdata <= data;
                if (exp_idx == LAST) begin
                    done <= 1'b1;
                end else begin
                    exp_idx <= exp_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/init_loader.sv
// rtl/init_loader.sv - sequences the four init streams into array writes and gates core reset
module init_loader
    import init_pkg::*;
(
    input  logic         clk,
    input  logic         rst_i,
    init_loader_if.master bus
);

    init_state_t        state;
    logic [TMR_W-1:0]   tmr;
    logic               tmr_hit;
    logic               en;
    logic               btb_done, bht_done, rf_done, dmem_done;
    logic               all_done;
    logic [REG_DW-1:0]  reg_data;
    logic               mem_ok;
    logic [MEM_AW-1:0]  mem_idx;

    assign tmr_hit  = (tmr == TMR_W'(TIMEOUT));
    // Nothing is captured on the timeout cycle, so no strobe can land with the error flag.
    assign en       = (state == LOAD) && !tmr_hit;
    assign all_done = btb_done & bht_done & rf_done & dmem_done;
    assign reg_data = (bus.reg_addr == '0) ? '0 : bus.reg_init;
    assign mem_ok   = ~|bus.mem_addr[MEM_ADDR_W-1:MEM_AW];

    init_stream_tracker #(.DEPTH(BTB_DEPTH), .AW(BTB_AW), .DW(BTB_DW), .LAG(0)) u_btb (
        .clk(clk), .rst(rst_i), .en(en), .addr_ok(1'b1),
        .addr(bus.btb_addr), .data(bus.btb_init),
        .we(bus.btb_we_o), .waddr(bus.btb_waddr_o), .wdata(bus.btb_wdata_o), .done(btb_done)
    );

    init_stream_tracker #(.DEPTH(BHT_DEPTH), .AW(BHT_AW), .DW(BHT_DW), .LAG(0)) u_bht (
        .clk(clk), .rst(rst_i), .en(en), .addr_ok(1'b1),
        .addr(bus.bht_addr), .data(bus.bht_init),
        .we(bus.bht_we_o), .waddr(bus.bht_waddr_o), .wdata(bus.bht_wdata_o), .done(bht_done)
    );

    init_stream_tracker #(.DEPTH(REG_DEPTH), .AW(REG_AW), .DW(REG_DW), .LAG(0)) u_rf (
        .clk(clk), .rst(rst_i), .en(en), .addr_ok(1'b1),
        .addr(bus.reg_addr), .data(reg_data),
        .we(bus.rf_we_o), .waddr(bus.rf_waddr_o), .wdata(bus.rf_wdata_o), .done(rf_done)
    );

    init_stream_tracker #(.DEPTH(MEM_DEPTH), .AW(MEM_AW), .DW(MEM_DW), .LAG(1)) u_dmem (
        .clk(clk), .rst(rst_i), .en(en), .addr_ok(mem_ok),
        .addr(bus.mem_addr[MEM_AW-1:0]), .data(bus.mem_init),
        .we(bus.dmem_we_o), .waddr(mem_idx), .wdata(bus.dmem_wdata_o), .done(dmem_done)
    );

    assign bus.dmem_waddr_o = {{(MEM_ADDR_W-MEM_AW-2){1'b0}}, mem_idx, 2'b00};

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state           <= LOAD;
            tmr             <= '0;
            bus.cpu_rst_o   <= 1'b1;
            bus.init_done_o <= 1'b0;
            bus.init_err_o  <= 1'b0;
        end else begin
            if (!tmr_hit) begin
                tmr <= tmr + 1'b1;
            end
            case (state)
                LOAD: begin
                    if (all_done) begin
                        state           <= DONE;
                        bus.init_done_o <= 1'b1;
                        bus.cpu_rst_o   <= 1'b0;
                    end else if (tmr_hit) begin
                        state          <= ERR;
                        bus.init_err_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_init_loader.sv
// tb/tb_init_loader.sv - randomized and directed scoreboard bench for init_loader
module tb_init_loader;
    import init_pkg::*;

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk = ~clk;

    init_loader_if bus();
    init_loader dut (.clk(clk), .rst_i(rst_i), .bus(bus));

    typedef struct {
        int              cyc;
        longint unsigned addr;
        longint unsigned data;
    } wr_t;

    wr_t             q[4][$];
    int              depth[4] = '{256, 256, 32, 27};
    string           pname[4] = '{"btb", "bht", "rf", "dmem"};
    int              exp_i[4];
    bit              mdone[4];
    int              fin[4];
    bit              pv;
    longint unsigned pa;
    longint unsigned s_addr[4];
    longint unsigned s_data[4];
    int              wcnt[4][256];
    longint unsigned dmem_seen[32];
    longint unsigned rf_seen[32];
    logic [39:0]     btbtab[256];
    logic [1:0]      bhttab[256];
    logic [31:0]     regtab[32];
    logic [31:0]     memtab[32];
    int              last_ma;
    int              cyc;
    int              scen;
    int              rmod;
    bit              checking = 1'b0;
    int              n_cmp = 0;
    int              n_bad = 0;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < 4; t++) begin
            q[t].delete();
            exp_i[t] = 0;
            mdone[t] = 1'b0;
            fin[t]   = -1;
            for (int i = 0; i < 256; i++) wcnt[t][i] = 0;
        end
        for (int i = 0; i < 32; i++) begin
            dmem_seen[i] = '1;
            rf_seen[i]   = '1;
        end
        pv = 1'b0;
        pa = 0;
    endtask

    // Accept index exp_i[t]: the write shows up one cycle after the capture.
    task automatic accept(int t, int c, longint unsigned wa, longint unsigned wd);
        wr_t w;
        w.cyc  = c + 1;
        w.addr = wa;
        w.data = wd;
        q[t].push_back(w);
        if (exp_i[t] == depth[t] - 1) begin
            mdone[t] = 1'b1;
            fin[t]   = c + 1;
        end else begin
            exp_i[t]++;
        end
    endtask

    task automatic model_step(int c);
        if (c < TIMEOUT) begin
            for (int t = 0; t < 3; t++) begin
                if (!mdone[t] && s_addr[t] == longint'(exp_i[t]))
                    accept(t, c, s_addr[t], (t == 2 && exp_i[t] == 0) ? 0 : s_data[t]);
            end
            if (pv && !mdone[3] && pa == longint'(exp_i[3]))
                accept(3, c, longint'(exp_i[3]) * 4, s_data[3]);
        end
        pv = (s_addr[3] >> 5) == 0;
        pa = s_addr[3] & 31;
    endtask

    task automatic drive(int c);
        longint unsigned a[4];
        longint unsigned d[4];
        a[0] = c % 256;
        a[1] = c % 256;
        a[2] = c % 32;
        a[3] = c % 32;
        if (scen == 1 && c == 5) a[1] = 9;
        if (scen == 2) a[3] = 0;
        if (scen == 3) begin
            for (int t = 0; t < 3; t++)
                if ($urandom_range(rmod - 1) == 0) a[t] = $urandom_range(depth[t] - 1);
            if ($urandom_range(rmod - 1) == 0)
                a[3] = $urandom_range(31) | (64'd1 << $urandom_range(31, 5));
            else if ($urandom_range(rmod - 1) == 0)
                a[3] = $urandom_range(31);
        end
        d[0] = btbtab[a[0] % 256];
        d[1] = bhttab[a[1] % 256];
        d[2] = regtab[a[2] % 32];
        d[3] = memtab[last_ma];
        if (scen == 3) begin
            d[0] = {$urandom(), $urandom()} & 64'hFF_FFFF_FFFF;
            d[1] = $urandom_range(3);
            d[2] = $urandom();
            d[3] = $urandom();
        end
        last_ma = int'(a[3] % 32);
        bus.btb_addr = a[0][7:0];
        bus.btb_init = d[0][39:0];
        bus.bht_addr = a[1][7:0];
        bus.bht_init = d[1][1:0];
        bus.reg_addr = a[2][4:0];
        bus.reg_init = d[2][31:0];
        bus.mem_addr = a[3][31:0];
        bus.mem_init = d[3][31:0];
        s_addr = a;
        s_data = d;
    endtask

    task automatic port_cmp(int t, logic we, longint unsigned wa, longint unsigned wd);
        bit ew;
        longint unsigned idx;
        ew = q[t].size() > 0 && q[t][0].cyc == cyc;
        check({pname[t], "_we"}, 64'(we), 64'(ew));
        if (we === 1'b1) begin
            idx = (t == 3) ? wa >> 2 : wa;
            if (idx < 256) wcnt[t][idx]++;
            if (t == 3 && idx < 32) dmem_seen[idx] = wd;
            if (t == 2 && idx < 32) rf_seen[idx] = wd;
        end
        if (we === 1'b1 && ew) begin
            check({pname[t], "_waddr"}, wa, q[t][0].addr);
            check({pname[t], "_wdata"}, wd, q[t][0].data);
        end
        if (ew) void'(q[t].pop_front());
    endtask

    always @(negedge clk) begin
        if (checking) begin
            int done_at;
            bit all_fin;
            all_fin = 1'b1;
            done_at = 0;
            for (int t = 0; t < 4; t++) begin
                if (fin[t] < 0) all_fin = 1'b0;
                else if (fin[t] + 1 > done_at) done_at = fin[t] + 1;
            end
            if (!all_fin) done_at = 1 << 30;
            port_cmp(0, bus.btb_we_o, bus.btb_waddr_o, bus.btb_wdata_o);
            port_cmp(1, bus.bht_we_o, bus.bht_waddr_o, bus.bht_wdata_o);
            port_cmp(2, bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o);
            port_cmp(3, bus.dmem_we_o, bus.dmem_waddr_o, bus.dmem_wdata_o);
            check("init_done", 64'(bus.init_done_o), 64'(cyc >= done_at));
            check("cpu_rst", 64'(bus.cpu_rst_o), 64'(cyc < done_at));
            check("init_err", 64'(bus.init_err_o), 64'(done_at > TIMEOUT + 1 && cyc >= TIMEOUT + 1));
        end
    end

    task automatic start();
        checking = 1'b0;
        rst_i = 1'b1;
        #1;
        check("rst_we", 64'({bus.btb_we_o, bus.bht_we_o, bus.rf_we_o, bus.dmem_we_o}), 64'd0);
        check("rst_waddr", 64'(|{bus.btb_waddr_o, bus.bht_waddr_o, bus.rf_waddr_o, bus.dmem_waddr_o}), 64'd0);
        check("rst_wdata", 64'(|{bus.btb_wdata_o, bus.bht_wdata_o, bus.rf_wdata_o, bus.dmem_wdata_o}), 64'd0);
        check("rst_status", 64'({bus.cpu_rst_o, bus.init_done_o, bus.init_err_o}), 64'b100);
        @(posedge clk);
        #1;
        model_reset();
        cyc = 0;
        last_ma = 0;
        rst_i = 1'b0;
        drive(0);
        model_step(0);
        checking = 1'b1;
    endtask

    task automatic run_to(int n);
        while (cyc < n) begin
            @(posedge clk);
            cyc++;
            #1;
            drive(cyc);
            model_step(cyc);
        end
    endtask

    function automatic int bad_indices(int t);
        int b = 0;
        for (int i = 0; i < depth[t]; i++) if (wcnt[t][i] != 1) b++;
        return b;
    endfunction

    function automatic int total(int t);
        int s = 0;
        for (int i = 0; i < 256; i++) s += wcnt[t][i];
        return s;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            btbtab[i] = {$urandom(), $urandom()};
            bhttab[i] = 2'($urandom_range(3));
        end
        for (int i = 0; i < 32; i++) begin
            regtab[i] = $urandom();
            memtab[i] = $urandom();
        end
        regtab[0]  = 32'hDEAD;
        memtab[0]  = 32'd9;
        memtab[17] = 32'd9;
        memtab[18] = 32'd0;
        rmod = 4;

        // Clean sources, then 600 more cycles of activity after DONE.
        scen = 0;
        start();
        run_to(256);
        check("clean_done_256", 64'(bus.init_done_o), 64'd0);
        check("clean_cpurst_256", 64'(bus.cpu_rst_o), 64'd1);
        run_to(257);
        check("clean_done_257", 64'(bus.init_done_o), 64'd1);
        check("clean_cpurst_257", 64'(bus.cpu_rst_o), 64'd0);
        check("model_btb_fin", 64'(fin[0]), 64'd256);
        run_to(857);
        for (int t = 0; t < 4; t++) begin
            check({pname[t], "_total"}, 64'(total(t)), 64'(depth[t]));
            check({pname[t], "_once"}, 64'(bad_indices(t)), 64'd0);
        end
        check("dmem_data_0", dmem_seen[0], 64'd9);
        check("dmem_data_17", dmem_seen[17], 64'd9);
        check("dmem_data_18", dmem_seen[18], 64'd0);
        check("rf_x0_zero", rf_seen[0], 64'd0);
        check("rf_data_1", rf_seen[1], 64'(regtab[1]));

        // BHT source skips index 5 on its first pass.
        scen = 1;
        start();
        run_to(512);
        check("skip_done_512", 64'(bus.init_done_o), 64'd0);
        run_to(513);
        check("skip_done_513", 64'(bus.init_done_o), 64'd1);
        run_to(600);
        check("skip_bht_total", 64'(total(1)), 64'd256);

        // Memory stream stuck at address 0.
        scen = 2;
        start();
        run_to(1024);
        check("stuck_err_1024", 64'(bus.init_err_o), 64'd0);
        run_to(1025);
        check("stuck_err_1025", 64'(bus.init_err_o), 64'd1);
        run_to(1100);
        check("stuck_cpurst", 64'(bus.cpu_rst_o), 64'd1);
        check("stuck_dmem_total", 64'(total(3)), 64'd1);

        // Reset dropped in mid-load, then a clean reload.
        scen = 0;
        start();
        run_to(100);
        start();
        run_to(1);
        check("rerst_first_btb_we", 64'(bus.btb_we_o), 64'd1);
        check("rerst_first_btb_idx", 64'(bus.btb_waddr_o), 64'd0);
        run_to(256);
        check("rerst_done_256", 64'(bus.init_done_o), 64'd0);
        run_to(257);
        check("rerst_done_257", 64'(bus.init_done_o), 64'd1);

        // Randomly disturbed sources at three disturbance rates.
        scen = 3;
        for (int r = 0; r < 3; r++) begin
            rmod = (r == 0) ? 1024 : (r == 1) ? 64 : 4;
            start();
            run_to(1200);
        end

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/init_loader.md
# init_loader

Boot-time write sequencer sitting directly downstream of the initialization pattern generator. It consumes the four free-running init streams (BTB, BHT, register file, data memory) and turns them into registered, single-pass write strobes into the real arrays. It tracks per-target completion, holds the core in reset until every array is loaded, and flags a stuck stream.

## Interface
- BTB_DEPTH, 256: BTB entries, index width 8
- BHT_DEPTH, 256: BHT entries, index width 8
- REG_DEPTH, 32: register-file entries, index width 5
- MEM_DEPTH, 27: data-memory words loaded
- TIMEOUT, 1024: cycles after reset before `init_err_o` fires if loading is incomplete
- clk  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- btb_init / btb_addr  in  40 / 8  BTB stream; data valid for the presented address in the same cycle
- bht_init / bht_addr  in  2 / 8  BHT stream; same-cycle data
- reg_init / reg_addr  in  32 / 5  register stream; same-cycle data
- mem_init / mem_addr  in  32 / 32  memory stream; data lags address by one cycle
- btb_we_o, btb_waddr_o, btb_wdata_o  out  1, 8, 40  BTB write port
- bht_we_o, bht_waddr_o, bht_wdata_o  out  1, 8, 2  BHT write port
- rf_we_o, rf_waddr_o, rf_wdata_o  out  1, 5, 32  register-file write port
- dmem_we_o, dmem_waddr_o, dmem_wdata_o  out  1, 32, 32  data-memory write port; byte address
- cpu_rst_o  out  1  holds the core in reset while high
- init_done_o  out  1  all four targets loaded
- init_err_o  out  1  timeout expired before done; sticky

## Operation
- Top FSM: LOAD → DONE, or LOAD → ERR. Reset enters LOAD.
  - LOAD: each tracker runs independently.
  - DONE: all four trackers finished. All `*_we_o` are forced to 0, and further stream activity is ignored.
  - ERR: all `*_we_o` are forced to 0, and `cpu_rst_o` stays 1.
- Each tracker has an expected-index counter starting at 0 and a done flag.
- Same-cycle streams (BTB, BHT, register):
  - When the stream address equals the expected index and the tracker is not done, write that address with the current data, then increment the expected index.
  - The write that uses the last index (DEPTH-1) sets done.
  - An address that does not match is ignored. The tracker waits for the source to wrap around, so a skipped or out-of-order source recovers on the next pass.
- Memory tracker:
  - The source data refers to address−1, so pairing uses the address delayed by one cycle.
  - The tracker captures when the delayed address equals the expected index and the delayed address is below MEM_DEPTH. The data written is the current `mem_init`.
  - `dmem_waddr_o` = index×4. Done is set after index 26.
- Register index 0: the write is issued with `rf_wdata_o` forced to 0, regardless of the stream data.
- Width rules:
  - `btb_addr` and `bht_addr` compare as 8 bits; `reg_addr` as 5 bits.
  - `mem_addr[31:5]` non-zero counts as a mismatch.
- Simultaneous writes to all four ports in one cycle are legal; the ports are independent.
- Reset mid-load: all counters, done flags, the timeout counter and all outputs clear asynchronously, and loading restarts from index 0.

## Timing
- Reset values:
  - all `*_we_o`, `*_waddr_o`, `*_wdata_o` = 0
  - `cpu_rst_o` = 1
  - `init_done_o` = 0
  - `init_err_o` = 0
- Write latency: matching input in cycle N gives a registered write strobe in cycle N+1. Each strobe is high for exactly one cycle per index.
- Completion:
  - `init_done_o` rises the cycle after the last of the four final write strobes.
  - `cpu_rst_o` falls in that same cycle.
- Error:
  - The timeout counter saturates at TIMEOUT.
  - If it reaches TIMEOUT while still in LOAD, `init_err_o` rises on the next cycle.
  - Done and timeout in the same cycle: done wins.
- With clean sources starting at 0, the BTB/BHT finish bounds load time: final strobe in cycle 256 after reset release, `init_done_o` in cycle 257.

## Structure
- Package `init_pkg`:
  - depth constants and index widths
  - TIMEOUT
  - FSM state enum {LOAD, DONE, ERR}
- Sub-module `init_stream_tracker`, parameterized by DEPTH, AW, DW and LAG (0 or 1):
  - handles expected-index compare, the registered write port and the done flag
  - instantiated four times
  - the x0-zeroing and byte-address shift live in the top level

## Test plan
- Clean sources from reset:
  - 256 BTB, 256 BHT, 32 RF and 27 DMEM strobes, each index written exactly once
  - `dmem_wdata_o` for index 0 = 9, index 17 = 9, index 18 = 0
  - `init_done_o`=1 and `cpu_rst_o`=0 at cycle 257
- Register stream with `reg_init`=0xDEAD at address 0: `rf_waddr_o`=0 is written with data 0; address 1 is written with stream data.
- BHT source skips address 5 on the first pass: no write for indices above 4 until the wrap; index 5 is written on the second pass; done is delayed by about 256 cycles.
- Memory stream held at address 0 forever: `init_err_o`=1 at cycle TIMEOUT+1; `cpu_rst_o` stays 1; no strobes after that.
- Reset asserted at cycle 100, then released: all outputs return to reset values asynchronously; the first BTB strobe after release carries index 0; completion occurs 257 cycles after release.
- After DONE, the sources keep cycling: zero further write strobes for 600 cycles.
